// File: rtl/timer_sequencer.sv
// Kitchen timer control FSM: owns the MM:SS BCD digits, handles set/start/pause/clear buttons,
// counts down once per second while running and holds the alarm for a fixed number of seconds.
module timer_sequencer #(
  parameter int CLKS_PER_SEC = 100,
  parameter int ALARM_SECS   = 10
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       btn_start,
  input  logic       btn_clear,
  input  logic       btn_min_inc,
  input  logic       btn_sec_inc,
  output logic [7:0] minutes_upper,
  output logic [7:0] minutes_lower,
  output logic [7:0] seconds_upper,
  output logic [7:0] seconds_lower,
  output logic       running,
  output logic       alarm
);

  localparam int PW = (CLKS_PER_SEC > 1) ? $clog2(CLKS_PER_SEC) : 1;
  localparam int AW = (ALARM_SECS > 1) ? $clog2(ALARM_SECS) : 1;
  localparam logic [PW-1:0] PRE_MAX  = PW'(CLKS_PER_SEC - 1);
  localparam logic [AW-1:0] ASEC_MAX = AW'(ALARM_SECS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_ALARM = 2'd3
  } state_t;

  state_t        state_r, state_s;
  logic [3:0]    mu_r, ml_r, su_r, sl_r;
  logic [3:0]    mu_s, ml_s, su_s, sl_s;
  logic [PW-1:0] pre_r, pre_s;
  logic [AW-1:0] asec_r, asec_s;
  logic          running_r, alarm_r;
  logic [15:0]   time_s, dec_s;
  logic [7:0]    min_inc_s, sec_inc_s;
  logic          time_zero_s, any_btn_s, pre_term_s;

  // One-second BCD decrement with borrow; callers guarantee the time is non-zero.
  function automatic logic [15:0] time_dec(input logic [15:0] t);
    logic [3:0] mu, ml, su, sl;
    {mu, ml, su, sl} = t;
    if (sl != 4'd0) begin
      sl = sl - 4'd1;
    end else begin
      sl = 4'd9;
      if (su != 4'd0) begin
        su = su - 4'd1;
      end else begin
        su = 4'd5;
        if (ml != 4'd0) begin
          ml = ml - 4'd1;
        end else begin
          ml = 4'd9;
          mu = (mu != 4'd0) ? (mu - 4'd1) : 4'd0;
        end
      end
    end
    return {mu, ml, su, sl};
  endfunction

  // Two-digit BCD increment that wraps to 00 after hi_max/9.
  function automatic logic [7:0] pair_inc(input logic [7:0] pair, input logic [3:0] hi_max);
    logic [3:0] hi, lo;
    {hi, lo} = pair;
    if (lo >= 4'd9) begin
      lo = 4'd0;
      hi = (hi >= hi_max) ? 4'd0 : (hi + 4'd1);
    end else begin
      lo = lo + 4'd1;
    end
    return {hi, lo};
  endfunction

  assign time_s      = {mu_r, ml_r, su_r, sl_r};
  assign time_zero_s = (time_s == 16'h0000);
  assign dec_s       = time_dec(time_s);
  assign min_inc_s   = pair_inc({mu_r, ml_r}, 4'd9);
  assign sec_inc_s   = pair_inc({su_r, sl_r}, 4'd5);
  assign any_btn_s   = btn_start | btn_clear | btn_min_inc | btn_sec_inc;
  assign pre_term_s  = (pre_r == PRE_MAX);

  // Next-state, digit and prescaler logic; buttons resolve as clear > start > inc.
  always_comb begin
    state_s = state_r;
    mu_s    = mu_r;
    ml_s    = ml_r;
    su_s    = su_r;
    sl_s    = sl_r;
    pre_s   = pre_r;
    asec_s  = asec_r;
    case (state_r)
      ST_IDLE: begin
        pre_s  = {PW{1'b0}};
        asec_s = {AW{1'b0}};
        if (btn_clear) begin
          {mu_s, ml_s, su_s, sl_s} = 16'h0000;
        end else if (btn_start && !time_zero_s) begin
          state_s = ST_RUN;
        end else begin
          // A start at 00:00 is ignored, so any increment pressed with it still lands.
          if (btn_min_inc) begin
            {mu_s, ml_s} = min_inc_s;
          end else begin
            {mu_s, ml_s} = {mu_r, ml_r};
          end
          if (btn_sec_inc) begin
            {su_s, sl_s} = sec_inc_s;
          end else begin
            {su_s, sl_s} = {su_r, sl_r};
          end
        end
      end
      ST_RUN: begin
        if (btn_clear) begin
          state_s = ST_IDLE;
          {mu_s, ml_s, su_s, sl_s} = 16'h0000;
          pre_s = {PW{1'b0}};
        end else if (btn_start) begin
          state_s = ST_PAUSE;
        end else if (pre_term_s) begin
          pre_s = {PW{1'b0}};
          {mu_s, ml_s, su_s, sl_s} = dec_s;
          if (dec_s == 16'h0000) begin
            state_s = ST_ALARM;
            asec_s  = {AW{1'b0}};
          end else begin
            state_s = ST_RUN;
          end
        end else begin
          pre_s = pre_r + PW'(1);
        end
      end
      ST_PAUSE: begin
        if (btn_clear) begin
          state_s = ST_IDLE;
          {mu_s, ml_s, su_s, sl_s} = 16'h0000;
          pre_s = {PW{1'b0}};
        end else if (btn_start) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_PAUSE;
        end
      end
      ST_ALARM: begin
        {mu_s, ml_s, su_s, sl_s} = 16'h0000;
        if (any_btn_s) begin
          state_s = ST_IDLE;
          pre_s   = {PW{1'b0}};
          asec_s  = {AW{1'b0}};
        end else if (pre_term_s) begin
          pre_s = {PW{1'b0}};
          if (asec_r == ASEC_MAX) begin
            state_s = ST_IDLE;
            asec_s  = {AW{1'b0}};
          end else begin
            asec_s = asec_r + AW'(1);
          end
        end else begin
          pre_s = pre_r + PW'(1);
        end
      end
      default: begin
        state_s = ST_IDLE;
        {mu_s, ml_s, su_s, sl_s} = 16'h0000;
        pre_s  = {PW{1'b0}};
        asec_s = {AW{1'b0}};
      end
    endcase
  end

  // State, digit, prescaler and status-flag registers.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_r   <= ST_IDLE;
      mu_r      <= 4'd0;
      ml_r      <= 4'd0;
      su_r      <= 4'd0;
      sl_r      <= 4'd0;
      pre_r     <= {PW{1'b0}};
      asec_r    <= {AW{1'b0}};
      running_r <= 1'b0;
      alarm_r   <= 1'b0;
    end else begin
      state_r   <= state_s;
      mu_r      <= mu_s;
      ml_r      <= ml_s;
      su_r      <= su_s;
      sl_r      <= sl_s;
      pre_r     <= pre_s;
      asec_r    <= asec_s;
      running_r <= (state_s == ST_RUN);
      alarm_r   <= (state_s == ST_ALARM);
    end
  end

  assign minutes_upper = {4'h0, mu_r};
  assign minutes_lower = {4'h0, ml_r};
  assign seconds_upper = {4'h0, su_r};
  assign seconds_lower = {4'h0, sl_r};
  assign running       = running_r;
  assign alarm         = alarm_r;

endmodule

// File: tb/tb_timer_sequencer.sv
// Bench for timer_sequencer: a vector table, directed multi-cycle sequences, and random
// button traffic compared against a seconds-based reference model.
module tb_timer_sequencer;
  localparam int CPS   = 100;
  localparam int ASECS = 10;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_ALARM = 3;

  logic       CLK = 1'b0;
  logic       reset;
  logic       btn_start, btn_clear, btn_min_inc, btn_sec_inc;
  logic [7:0] minutes_upper, minutes_lower, seconds_upper, seconds_lower;
  logic       running, alarm;

  int checks   = 0;
  int failures = 0;

  int m_mode, m_secs, m_pre, m_acnt;

  timer_sequencer #(.CLKS_PER_SEC(CPS), .ALARM_SECS(ASECS)) dut (
    .CLK(CLK), .reset(reset),
    .btn_start(btn_start), .btn_clear(btn_clear),
    .btn_min_inc(btn_min_inc), .btn_sec_inc(btn_sec_inc),
    .minutes_upper(minutes_upper), .minutes_lower(minutes_lower),
    .seconds_upper(seconds_upper), .seconds_lower(seconds_lower),
    .running(running), .alarm(alarm)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic st, cl, mi, si;
    int   mm, ss;
    logic run, al;
  } vec_t;

  function automatic void m_reset();
    m_mode = M_IDLE; m_secs = 0; m_pre = 0; m_acnt = 0;
  endfunction

  // Reference behaviour: time held as total seconds, alarm as a flat cycle count.
  function automatic void m_step(input logic st, input logic cl, input logic mi, input logic si);
    int mm, ss;
    case (m_mode)
      M_IDLE: begin
        if (cl) m_secs = 0;
        else if (st && m_secs != 0) begin m_mode = M_RUN; m_pre = 0; end
        else begin
          mm = m_secs / 60; ss = m_secs % 60;
          if (mi) mm = (mm + 1) % 100;
          if (si) ss = (ss + 1) % 60;
          m_secs = mm * 60 + ss;
        end
      end
      M_RUN: begin
        if (cl) begin m_mode = M_IDLE; m_secs = 0; m_pre = 0; end
        else if (st) m_mode = M_PAUSE;
        else if (m_pre == CPS - 1) begin
          m_pre = 0; m_secs = m_secs - 1;
          if (m_secs == 0) begin m_mode = M_ALARM; m_acnt = 0; end
        end else m_pre = m_pre + 1;
      end
      M_PAUSE: begin
        if (cl) begin m_mode = M_IDLE; m_secs = 0; m_pre = 0; end
        else if (st) m_mode = M_RUN;
      end
      default: begin
        if (st || cl || mi || si || m_acnt == CPS * ASECS - 1) begin m_mode = M_IDLE; m_pre = 0; end
        else m_acnt = m_acnt + 1;
      end
    endcase
  endfunction

  function automatic logic [33:0] exp_vec(input int mm, input int ss, input logic run, input logic al);
    return {8'(mm / 10), 8'(mm % 10), 8'(ss / 10), 8'(ss % 10), run, al};
  endfunction

  task automatic check_vec(input string name, input logic [33:0] exp);
    logic [33:0] act;
    act = {minutes_upper, minutes_lower, seconds_upper, seconds_lower, running, alarm};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %02h%02h:%02h%02h run=%0b alarm=%0b, want %02h%02h:%02h%02h run=%0b alarm=%0b",
               name, act[33:26], act[25:18], act[17:10], act[9:2], act[1], act[0],
               exp[33:26], exp[25:18], exp[17:10], exp[9:2], exp[1], exp[0]);
    end
  endtask

  task automatic check_time(input string name, input int mm, input int ss, input logic run, input logic al);
    check_vec(name, exp_vec(mm, ss, run, al));
  endtask

  task automatic check_model(input string name);
    check_vec(name, exp_vec(m_secs / 60, m_secs % 60, m_mode == M_RUN, m_mode == M_ALARM));
  endtask

  task automatic tick(input logic st, input logic cl, input logic mi, input logic si);
    btn_start = st; btn_clear = cl; btn_min_inc = mi; btn_sec_inc = si;
    @(posedge CLK);
    m_step(st, cl, mi, si);
    @(negedge CLK);
    btn_start = 1'b0; btn_clear = 1'b0; btn_min_inc = 1'b0; btn_sec_inc = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic set_time(input int mm, input int ss);
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (mm) tick(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (ss) tick(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    reset = 1'b0;
    m_reset();
    @(negedge CLK);
    reset = 1'b1;
    @(negedge CLK);
  endtask

  vec_t vecs[15];

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1, 0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1, 1, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 2, 2, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2, 2, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2, 2, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2, 2, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2, 2, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2, 2, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 0, 1, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b1, 1, 1, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b1, 1, 1, 1'b1, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0};

    reset = 1'b0;
    btn_start = 1'b0; btn_clear = 1'b0; btn_min_inc = 1'b0; btn_sec_inc = 1'b0;
    m_reset();
    repeat (2) @(negedge CLK);
    check_time("reset_state", 0, 0, 1'b0, 1'b0);
    reset = 1'b1;
    @(negedge CLK);

    for (int i = 0; i < 15; i++) begin
      tick(vecs[i].st, vecs[i].cl, vecs[i].mi, vecs[i].si);
      check_time($sformatf("vec%0d", i), vecs[i].mm, vecs[i].ss, vecs[i].run, vecs[i].al);
    end

    // Asynchronous reset in the middle of a countdown.
    set_time(5, 30);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    idle(37);
    #2 reset = 1'b0;
    m_reset();
    #1 check_time("async_reset", 0, 0, 1'b0, 1'b0);
    @(negedge CLK);
    reset = 1'b1;
    idle(3);
    check_time("after_reset", 0, 0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    check_time("idle_after_reset", 1, 0, 1'b0, 1'b0);

    // Set-mode wrapping.
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (3) tick(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (61) tick(1'b0, 1'b0, 1'b0, 1'b1);
    check_time("set_03_01", 3, 1, 1'b0, 1'b0);
    repeat (96) tick(1'b0, 1'b0, 1'b1, 1'b0);
    check_time("set_99_01", 99, 1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    check_time("min_wrap", 0, 1, 1'b0, 1'b0);

    // Countdown cadence and borrow chain.
    set_time(1, 0);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    check_time("run_start", 1, 0, 1'b1, 1'b0);
    idle(99);
    check_time("pre_first_dec", 1, 0, 1'b1, 1'b0);
    idle(1);
    check_time("dec_00_59", 0, 59, 1'b1, 1'b0);
    idle(100);
    check_time("dec_00_58", 0, 58, 1'b1, 1'b0);
    set_time(10, 0);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    idle(99);
    check_time("pre_borrow", 10, 0, 1'b1, 1'b0);
    idle(1);
    check_time("borrow_09_59", 9, 59, 1'b1, 1'b0);

    // Reaching zero, alarm duration, and button exit from alarm.
    set_time(0, 2);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    idle(100);
    check_time("dec_00_01", 0, 1, 1'b1, 1'b0);
    idle(100);
    check_time("alarm_on", 0, 0, 1'b0, 1'b1);
    idle(999);
    check_time("alarm_held", 0, 0, 1'b0, 1'b1);
    idle(1);
    check_time("alarm_timeout", 0, 0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    idle(100);
    check_time("alarm_again", 0, 0, 1'b0, 1'b1);
    idle(5);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    check_time("alarm_btn_exit", 0, 0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    check_time("idle_after_alarm", 0, 1, 1'b0, 1'b0);

    // Pause freezes the prescaler, including at its terminal count.
    set_time(0, 30);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    idle(40);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    check_time("paused", 0, 30, 1'b0, 1'b0);
    idle(500);
    check_time("pause_hold", 0, 30, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    idle(59);
    check_time("resume_pre", 0, 30, 1'b1, 1'b0);
    idle(1);
    check_time("resume_dec", 0, 29, 1'b1, 1'b0);
    idle(99);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    check_time("pause_at_term", 0, 29, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    idle(1);
    check_time("term_resume_dec", 0, 28, 1'b1, 1'b0);

    // Simultaneous buttons.
    set_time(1, 0);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    idle(10);
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    check_time("clear_beats_start", 0, 0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    idle(2);
    check_time("start_at_zero", 0, 0, 1'b0, 1'b0);

    // Random traffic against the reference model.
    do_reset();
    check_model("rand_reset");
    for (int i = 0; i < 5000; i++) begin
      tick(($urandom % 30) == 0, ($urandom % 400) == 0,
           ($urandom % 80) == 0, ($urandom % 10) == 0);
      check_model($sformatf("rand%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
